// File: rtl/dp_instr_fetch.sv
// Byte-serial instruction assembler feeding a small FIFO for the execute stage.
// Register ops are one byte, immediate ops two bytes, and illegal first bytes are dropped.
module dp_instr_fetch #(
  parameter int DEPTH = 4,
  parameter int LVLW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_opcode,
  output logic [1:0]      out_rd,
  output logic [1:0]      out_rs,
  output logic [7:0]      out_imm,
  output logic            err_illegal,
  output logic [LVLW-1:0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);

  typedef enum logic {IDLE, IMM} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LVLW-1:0] level;
  logic [3:0]      lat_op;
  logic [1:0]      lat_rd, lat_rs;
  logic            accept, pop, push, latch, err_set;
  logic [15:0]     push_data;
  logic [3:0]      opcode;

  assign opcode    = in_byte[7:4];
  // in_ready depends only on the registered level and flush, never on the other handshake inputs
  assign in_ready  = (level != FULL_LVL) && !flush;
  assign out_valid = (level != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign fifo_level = level;
  assign {out_opcode, out_rd, out_rs, out_imm} = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    if (opcode[3:2] == 2'b10) state_nxt = IMM;
        IMM:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    latch     = 1'b0;
    err_set   = 1'b0;
    push_data = '0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!opcode[3]) begin
            push      = 1'b1;
            push_data = {in_byte, 8'h00};
          end else if (!opcode[2]) begin
            latch = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
        IMM: begin
          push      = 1'b1;
          push_data = {lat_op, lat_rd, lat_rs, in_byte};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_op <= '0;
      lat_rd <= '0;
      lat_rs <= '0;
    end else if (flush) begin
      lat_op <= '0;
      lat_rd <= '0;
      lat_rs <= '0;
    end else if (latch) begin
      lat_op <= opcode;
      lat_rd <= in_byte[3:2];
      lat_rs <= in_byte[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        err_illegal <= 1'b0;
    else if (flush) err_illegal <= 1'b0;
    else            err_illegal <= err_set;
  end

  // Storage is cleared on reset so the head fields read as zero while empty after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LVLW'(1);
        2'b01:   level <= level - LVLW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_instr_fetch.sv
// Scoreboard bench for dp_instr_fetch: a byte-stream decoder model predicts handshakes,
// levels and error pulses, and queues expected instructions that a monitor checks on pop.
module tb_dp_instr_fetch;
  localparam int DEPTH = 4;
  localparam int LVLW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [7:0]      in_byte = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [3:0]      out_opcode;
  logic [1:0]      out_rd, out_rs;
  logic [7:0]      out_imm;
  logic            err_illegal;
  logic [LVLW-1:0] fifo_level;

  dp_instr_fetch #(.DEPTH(DEPTH), .LVLW(LVLW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_imm(out_imm),
    .err_illegal(err_illegal), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected instruction words {opcode,rd,rs,imm} in issue order
  logic [15:0] exp_q[$];
  int          m_level = 0;
  bit          m_pending = 0;
  logic [7:0]  m_first = '0;
  bit          m_err = 0;
  bit          m_acc = 0;

  always @(negedge clk) begin
    bit exp_rdy, acc, pop, push;
    logic [15:0] word;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_err", err_illegal, 0);
      chk("rst_fields", {out_opcode, out_rd, out_rs, out_imm}, 0);
      exp_q.delete();
      m_level = 0; m_pending = 0; m_err = 0; m_acc = 0;
    end else begin
      exp_rdy = (m_level != DEPTH) && !flush;
      chk("in_ready", in_ready, exp_rdy);
      chk("fifo_level", fifo_level, m_level);
      chk("out_valid", out_valid, m_level != 0);
      chk("err_illegal", err_illegal, m_err);
      if (flush) begin
        exp_q.delete();
        m_level = 0; m_pending = 0; m_err = 0; m_acc = 0;
      end else begin
        acc  = in_valid && exp_rdy;
        pop  = (m_level != 0) && out_ready;
        push = 0;
        m_err = 0;
        word = '0;
        if (acc) begin
          if (m_pending) begin
            word = {m_first, in_byte};
            push = 1;
            m_pending = 0;
          end else if (in_byte < 8'h80) begin
            word = {in_byte, 8'h00};
            push = 1;
          end else if (in_byte < 8'hC0) begin
            m_first = in_byte;
            m_pending = 1;
          end else begin
            m_err = 1;
          end
        end
        if (push) exp_q.push_back(word);
        m_level = m_level + int'(push) - int'(pop);
        m_acc = acc;
      end
    end
  end

  // Monitor: compare the head against the scoreboard whenever the execute stage takes it
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", {out_opcode, out_rd, out_rs, out_imm}, e);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] b, input bit rdy, input bit fl);
    in_valid = v; in_byte = b; out_ready = rdy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    int n = 0;
    do begin
      step(1, b, rdy, 0);
      n++;
    end while (!m_acc && n < 64);
    if (!m_acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(8'h16, 0); send(8'h2B, 0); idle(2, 0);
    idle(4, 1);

    send(8'h87, 0); idle(1, 0); send(8'hA5, 0); idle(2, 0); idle(2, 1);

    send(8'hE0, 0); send(8'h30, 0); idle(2, 0); idle(2, 1);

    send(8'h01, 0); send(8'h12, 0); send(8'h23, 0); send(8'h34, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h85, 0, 0);
    step(1, 8'h85, 1, 0);
    step(1, 8'h85, 0, 0);
    send(8'h11, 0); idle(6, 1);

    for (int i = 0; i < 20; i++) step(1, 8'($urandom_range(0, 127)), 1, 0);
    idle(4, 1);

    send(8'h01, 0); send(8'h02, 0); send(8'h9F, 0);
    step(0, 8'h00, 0, 1);
    send(8'h05, 0); idle(2, 0); idle(2, 1);

    send(8'h01, 0); send(8'h02, 0); send(8'h9F, 0);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_level", fifo_level, 0);
    @(posedge clk); #1 rst = 1'b0;
    send(8'h05, 0); idle(2, 0); idle(2, 1);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0);
    idle(8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
